// File: rtl/stopwatch_core.sv
// Prescaled BCD stopwatch: tenths, seconds 00-59 and MIN_DIGITS minute digits with up/down count,
// preset load and run/pause control. Define STOPWATCH_LAP_EN to add the lap-hold display freeze.
module stopwatch_core #(
    parameter int TICK_DIV   = 10,
    parameter int MIN_DIGITS = 1
) (
    input  logic                    clk,
    input  logic                    r,
    input  logic                    en,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clr,
    input  logic                    dir,
    input  logic                    load,
    input  logic [7:0]              pre_s,
    input  logic [4*MIN_DIGITS-1:0] pre_m,
    input  logic                    lap,
    output logic [3:0]              q0,
    output logic [7:0]              qs,
    output logic [4*MIN_DIGITS-1:0] qm,
    output logic                    running,
    output logic                    co,
    output logic                    done
);
    localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
    localparam int            MW     = 4 * MIN_DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [3:0]    t_q, t_d;
    logic [7:0]    s_q, s_d;
    logic [MW-1:0] m_q, m_d;
    logic          dir_q, dir_d;
    logic          co_q, co_d;
    logic          done_q, done_d;

    logic [3:0]    t_inc, t_dec;
    logic [7:0]    s_inc, s_dec;
    logic [MW-1:0] m_inc, m_dec, m_pre;
    logic          inc_c, dec_b, inc_wrap, dec_zero, is_zero, tick;

    function automatic logic [3:0] clamp_dig(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    assign is_zero = (t_q == 4'd0) && (s_q == 8'd0) && (m_q == '0);
    assign tick    = (state_q == RUN) && (ps_q == PS_MAX);

    // Ripple-carry BCD increment across tenths, seconds (mod 60) and minute digits.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        inc_c = 1'b1;
        t_inc = 4'd0;
        s_inc = s_q;
        m_inc = m_q;
        if (t_q != 4'd9) begin
            t_inc = t_q + 4'd1;
            inc_c = 1'b0;
        end
        if (inc_c) begin
            if (s_q[3:0] != 4'd9) begin
                s_inc[3:0] = s_q[3:0] + 4'd1;
                inc_c      = 1'b0;
            end else begin
                s_inc[3:0] = 4'd0;
                if (s_q[7:4] != 4'd5) begin
                    s_inc[7:4] = s_q[7:4] + 4'd1;
                    inc_c      = 1'b0;
                end else begin
                    s_inc[7:4] = 4'd0;
                end
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (inc_c) begin
                if (m_q[4*i +: 4] != 4'd9) begin
                    m_inc[4*i +: 4] = m_q[4*i +: 4] + 4'd1;
                    inc_c           = 1'b0;
                end else begin
                    m_inc[4*i +: 4] = 4'd0;
                end
            end
        end
        inc_wrap = inc_c;
    end

    // Mirror-image borrow chain for counting down.
    always_comb begin
        dec_b = 1'b1;
        t_dec = 4'd9;
        s_dec = s_q;
        m_dec = m_q;
        if (t_q != 4'd0) begin
            t_dec = t_q - 4'd1;
            dec_b = 1'b0;
        end
        if (dec_b) begin
            if (s_q[3:0] != 4'd0) begin
                s_dec[3:0] = s_q[3:0] - 4'd1;
                dec_b      = 1'b0;
            end else begin
                s_dec[3:0] = 4'd9;
                if (s_q[7:4] != 4'd0) begin
                    s_dec[7:4] = s_q[7:4] - 4'd1;
                    dec_b      = 1'b0;
                end else begin
                    s_dec[7:4] = 4'd5;
                end
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (dec_b) begin
                if (m_q[4*i +: 4] != 4'd0) begin
                    m_dec[4*i +: 4] = m_q[4*i +: 4] - 4'd1;
                    dec_b           = 1'b0;
                end else begin
                    m_dec[4*i +: 4] = 4'd9;
                end
            end
        end
        dec_zero = (t_dec == 4'd0) && (s_dec == 8'd0) && (m_dec == '0);
    end

    always_comb begin
        m_pre = '0;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            m_pre[4*i +: 4] = clamp_dig(pre_m[4*i +: 4], 4'd9);
        end
    end

    // Control chain in priority order; load is only honoured outside RUN, so in RUN it falls through.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        t_d     = t_q;
        s_d     = s_q;
        m_d     = m_q;
        dir_d   = dir_q;
        co_d    = 1'b0;
        done_d  = 1'b0;
        if (!en) begin
            state_d = state_q;
        end else if (clr) begin
            state_d = IDLE;
            ps_d    = '0;
            t_d     = 4'd0;
            s_d     = 8'd0;
            m_d     = '0;
        end else if (load && (state_q != RUN)) begin
            ps_d = '0;
            t_d  = 4'd0;
            s_d  = {clamp_dig(pre_s[7:4], 4'd5), clamp_dig(pre_s[3:0], 4'd9)};
            m_d  = m_pre;
        end else if (stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (start && (state_q != RUN)) begin
            dir_d   = dir;
            state_d = (dir && is_zero) ? DONE : RUN;
        end else if (state_q == RUN) begin
            ps_d = tick ? '0 : ps_q + PW'(1);
            if (tick && !dir_q) begin
                t_d  = t_inc;
                s_d  = s_inc;
                m_d  = m_inc;
                co_d = inc_wrap;
            end else if (tick) begin
                t_d = t_dec;
                s_d = s_dec;
                m_d = m_dec;
                if (dec_zero) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
            ps_q    <= '0;
            t_q     <= 4'd0;
            s_q     <= 8'd0;
            m_q     <= '0;
            dir_q   <= 1'b0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            ps_q    <= ps_d;
            t_q     <= t_d;
            s_q     <= s_d;
            m_q     <= m_d;
            dir_q   <= dir_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == RUN);
    assign co      = co_q;
    assign done    = done_q;

`ifdef STOPWATCH_LAP_EN
    logic          hold_q, hold_d;
    logic [3:0]    lt_q, lt_d;
    logic [7:0]    ls_q, ls_d;
    logic [MW-1:0] lm_q, lm_d;

    // Setting the hold snapshots the live count; clearing it releases the display.
    always_comb begin
        hold_d = hold_q;
        lt_d   = lt_q;
        ls_d   = ls_q;
        lm_d   = lm_q;
        if (en && clr) begin
            hold_d = 1'b0;
        end else if (en && lap) begin
            hold_d = !hold_q;
            if (!hold_q) begin
                lt_d = t_q;
                ls_d = s_q;
                lm_d = m_q;
            end
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            hold_q <= 1'b0;
            lt_q   <= 4'd0;
            ls_q   <= 8'd0;
            lm_q   <= '0;
        end else begin
            hold_q <= hold_d;
            lt_q   <= lt_d;
            ls_q   <= ls_d;
            lm_q   <= lm_d;
        end
    end

    assign q0 = hold_q ? lt_q : t_q;
    assign qs = hold_q ? ls_q : s_q;
    assign qm = hold_q ? lm_q : m_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign q0 = t_q;
    assign qs = s_q;
    assign qm = m_q;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus randomized control traffic,
// compared every cycle against a model that keeps the count as a plain integer of tenths.
module tb_stopwatch_core;
    localparam int TD   = 4;
    localparam int MD   = 2;
    localparam int MW   = 4 * MD;
    localparam int MAXV = 600 * 100 - 1;

    logic          clk = 1'b0;
    logic          r, en, start, stop, clr, dir, load, lap;
    logic [7:0]    pre_s;
    logic [MW-1:0] pre_m;
    logic [3:0]    q0;
    logic [7:0]    qs;
    logic [MW-1:0] qm;
    logic          running, co, done;

    stopwatch_core #(.TICK_DIV(TD), .MIN_DIGITS(MD)) dut (
        .clk(clk), .r(r), .en(en), .start(start), .stop(stop), .clr(clr), .dir(dir),
        .load(load), .pre_s(pre_s), .pre_m(pre_m), .lap(lap),
        .q0(q0), .qs(qs), .qm(qm), .running(running), .co(co), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: count is an integer number of tenths.
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
    mstate_e m_st;
    int      m_val, m_ps, m_lap_val;
    logic    m_dir, m_co, m_done, m_hold;

    function automatic logic [7:0] sec_bcd(input int v);
        int s;
        s = (v / 10) % 60;
        return 8'((s / 10) * 16 + s % 10);
    endfunction

    function automatic logic [MW-1:0] min_bcd(input int v);
        int m;
        logic [MW-1:0] b;
        m = v / 600;
        b = '0;
        for (int i = 0; i < MD; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return b;
    endfunction

    function automatic int preset_val(input logic [7:0] ps, input logic [MW-1:0] pm);
        int st, so, mins, w;
        st = (ps[7:4] > 5) ? 5 : int'(ps[7:4]);
        so = (ps[3:0] > 9) ? 9 : int'(ps[3:0]);
        mins = 0;
        w = 1;
        for (int i = 0; i < MD; i++) begin
            mins = mins + w * ((pm[4*i +: 4] > 9) ? 9 : int'(pm[4*i +: 4]));
            w = w * 10;
        end
        return (st * 10 + so) * 10 + mins * 600;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_val = 0; m_ps = 0; m_dir = 1'b0;
        m_co = 1'b0; m_done = 1'b0; m_hold = 1'b0; m_lap_val = 0;
    endtask

    task automatic model_step();
        m_co = 1'b0;
        m_done = 1'b0;
        if (r) begin
            model_reset();
        end else if (en) begin
`ifdef STOPWATCH_LAP_EN
            if (clr) m_hold = 1'b0;
            else if (lap) begin
                if (!m_hold) m_lap_val = m_val;
                m_hold = !m_hold;
            end
`endif
            if (clr) begin
                m_st = M_IDLE; m_val = 0; m_ps = 0;
            end else if (load && m_st != M_RUN) begin
                m_val = preset_val(pre_s, pre_m); m_ps = 0;
            end else if (stop) begin
                if (m_st == M_RUN) m_st = M_PAUSE;
            end else if (start && m_st != M_RUN) begin
                m_dir = dir;
                m_st  = (dir && m_val == 0) ? M_DONE : M_RUN;
            end else if (m_st == M_RUN) begin
                if (m_ps == TD - 1) begin
                    m_ps = 0;
                    if (!m_dir) begin
                        if (m_val == MAXV) begin m_val = 0; m_co = 1'b1; end
                        else m_val = m_val + 1;
                    end else begin
                        m_val = m_val - 1;
                        if (m_val == 0) begin m_st = M_DONE; m_done = 1'b1; end
                    end
                end else begin
                    m_ps = m_ps + 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        int dv;
        dv = m_hold ? m_lap_val : m_val;
        check("q0", 32'(q0), 32'(dv % 10));
        check("qs", 32'(qs), 32'(sec_bcd(dv)));
        check("qm", 32'(qm), 32'(min_bcd(dv)));
        check("running", 32'(running), 32'(m_st == M_RUN));
        check("co", 32'(co), 32'(m_co));
        check("done", 32'(done), 32'(m_done));
    endtask

    logic co_seen;

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (co) co_seen = 1'b1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; clr = 0; load = 0; lap = 0;
    endtask

    task automatic pulse_load(input logic [7:0] s, input logic [MW-1:0] m);
        pre_s = s; pre_m = m; load = 1; cycle(); load = 0;
    endtask

    task automatic pulse_start(input logic d);
        dir = d; start = 1; cycle(); start = 0;
    endtask

    initial begin
        r = 1; en = 1; dir = 0; pre_s = 0; pre_m = 0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_q0", 32'(q0), 0);
        check("rst_qs", 32'(qs), 0);
        check("rst_qm", 32'(qm), 0);
        check("rst_running", 32'(running), 0);
        check("rst_co", 32'(co), 0);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        r = 0;

        // Count up one minute: 600 ticks of 4 cycles.
        co_seen = 1'b0;
        pulse_start(1'b0);
        repeat (600 * TD) cycle();
        check("one_min_q0", 32'(q0), 0);
        check("one_min_qs", 32'(qs), 32'h00);
        check("one_min_qm", 32'(qm), 32'h01);
        check("one_min_no_co", 32'(co_seen), 0);

        // Full-scale wrap from 99:59.0.
        stop = 1; cycle(); stop = 0;
        pulse_load(8'h59, 8'h99);
        pulse_start(1'b0);
        repeat (9 * TD) cycle();
        check("wrap_pre_q0", 32'(q0), 9);
        repeat (TD) cycle();
        check("wrap_qs", 32'(qs), 0);
        check("wrap_qm", 32'(qm), 0);
        check("wrap_co", 32'(co), 1);
        check("wrap_running", 32'(running), 1);
        repeat (2 * TD) cycle();

        // Asynchronous reset between edges.
        #1 r = 1;
        model_reset();
        #1;
        check("async_q0", 32'(q0), 0);
        check("async_qs", 32'(qs), 0);
        check("async_running", 32'(running), 0);
        cycle();
        r = 0;
        cycle();

        // Countdown from 01.0 to zero, then frozen.
        pulse_load(8'h01, 8'h00);
        pulse_start(1'b1);
        repeat (10 * TD) cycle();
        check("cd_zero_qs", 32'(qs), 0);
        check("cd_done", 32'(done), 1);
        check("cd_not_running", 32'(running), 0);
        repeat (20 * TD) cycle();
        check("cd_frozen_q0", 32'(q0), 0);
        check("cd_frozen_qs", 32'(qs), 0);
        pulse_start(1'b1);
        check("cd_restart_ignored", 32'(running), 0);

        // Simultaneous start and stop in IDLE.
        clr = 1; cycle(); clr = 0;
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        check("start_stop_idle", 32'(running), 0);

        // Pause with the prescaler at 2, resume, tick follows one RUN cycle later.
        pulse_start(1'b0);
        repeat (2) cycle();
        stop = 1; cycle(); stop = 0;
        repeat (3) cycle();
        pulse_start(1'b0);
        cycle();
        check("resume_no_tick_yet", 32'(q0), 0);
        cycle();
        check("resume_tick", 32'(q0), 1);

        // load while running is ignored; seconds clamp on reload afterwards.
        pulse_load(8'h30, 8'h00);
        check("load_in_run_qs", 32'(qs), 0);
        stop = 1; cycle(); stop = 0;
        pulse_load(8'h7C, 8'hA3);
        check("clamp_qs", 32'(qs), 32'h59);
        check("clamp_qm", 32'(qm), 32'h93);

        // Zero-count start downward goes straight to DONE with no pulse.
        clr = 1; cycle(); clr = 0;
        pulse_start(1'b1);
        check("zero_down_done_pulse", 32'(done), 0);
        check("zero_down_running", 32'(running), 0);

`ifdef STOPWATCH_LAP_EN
        clr = 1; cycle(); clr = 0;
        pulse_load(8'h05, 8'h00);
        pulse_start(1'b0);
        lap = 1; cycle(); lap = 0;
        repeat (30 * TD - 1) cycle();
        check("lap_hold_qs", 32'(qs), 32'h05);
        check("lap_hold_running", 32'(running), 1);
        lap = 1; cycle(); lap = 0;
        check("lap_release_qs", 32'(qs), 32'h08);
        check("lap_release_q0", 32'(q0), 0);
`endif

        // Randomized control traffic.
        clr = 1; cycle(); clr = 0;
        for (int n = 0; n < 4000; n++) begin
            en    = ($urandom_range(0, 15) != 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            clr   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 29) == 0);
            lap   = ($urandom_range(0, 39) == 0);
            dir   = 1'($urandom);
            pre_s = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            pre_m = ($urandom_range(0, 1) == 0) ? '0 : MW'($urandom);
            cycle();
        end
        idle_inputs();
        en = 1;
        cycle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
